// File: rtl/qa_shim_c0_read_tag_remap.sv
// qa_shim_c0_read_tag_remap
// CCI channel-0 read tag remapping shim between the AFU and QLP.
// AFU read-request tags are swapped for compact local slot indices on the way out
// and restored on the way back, so out-of-order responses still carry AFU tags.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   afu_c0_tx_*              AFU read requests in, almost-full back to AFU
//   afu_c0_rx_*              responses to AFU (tag restored), other valids forwarded
//   qlp_c0_tx_*              remapped requests to QLP, QLP almost-full in
//   qlp_c0_rx_*              responses from QLP
//   outstanding              number of busy slots
//   err_overflow             sticky: request dropped, no free slot
//   err_unknown_tag          sticky: read response tag not busy or out of range
module qa_shim_c0_read_tag_remap #(
  parameter int unsigned CCI_DATA_WIDTH   = 512,
  parameter int unsigned CCI_RX_HDR_WIDTH = 18,
  parameter int unsigned CCI_TX_HDR_WIDTH = 61,
  parameter int unsigned CCI_TAG_WIDTH    = 14,
  parameter int unsigned N_TAGS           = 64,
  parameter int unsigned ALM_FULL_THRESH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CCI_TX_HDR_WIDTH-1:0] afu_c0_tx_hdr,
  input  logic                        afu_c0_tx_rd_valid,
  output logic                        afu_c0_tx_alm_full,
  output logic [CCI_RX_HDR_WIDTH-1:0] afu_c0_rx_hdr,
  output logic [CCI_DATA_WIDTH-1:0]   afu_c0_rx_data,
  output logic                        afu_c0_rx_rd_valid,
  output logic [3:0]                  afu_c0_rx_other_valid,
  output logic [CCI_TX_HDR_WIDTH-1:0] qlp_c0_tx_hdr,
  output logic                        qlp_c0_tx_rd_valid,
  input  logic                        qlp_c0_tx_alm_full,
  input  logic [CCI_RX_HDR_WIDTH-1:0] qlp_c0_rx_hdr,
  input  logic [CCI_DATA_WIDTH-1:0]   qlp_c0_rx_data,
  input  logic                        qlp_c0_rx_rd_valid,
  input  logic [3:0]                  qlp_c0_rx_other_valid,
  output logic [$clog2(N_TAGS):0]     outstanding,
  output logic                        err_overflow,
  output logic                        err_unknown_tag
);

  localparam int unsigned IdxW = $clog2(N_TAGS);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned TagW = CCI_TAG_WIDTH;

  logic [N_TAGS-1:0] busy_q, busy_d;
  logic [TagW-1:0]   tag_mem_q [N_TAGS];
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_unknown_q, err_unknown_d;

  logic [CCI_TX_HDR_WIDTH-1:0] qlp_tx_hdr_q, qlp_tx_hdr_d;
  logic                        qlp_tx_valid_q, qlp_tx_valid_d;
  logic [CCI_RX_HDR_WIDTH-1:0] afu_rx_hdr_q, afu_rx_hdr_d;
  logic [CCI_DATA_WIDTH-1:0]   afu_rx_data_q, afu_rx_data_d;
  logic                        afu_rx_valid_q, afu_rx_valid_d;
  logic [3:0]                  afu_rx_other_q, afu_rx_other_d;

  logic            any_free;
  logic [IdxW-1:0] free_idx;
  logic            alloc;
  logic [TagW-1:0] rsp_tag;
  logic [IdxW-1:0] rsp_idx;
  logic            rsp_in_range;
  logic            rsp_hit;
  logic [CntW-1:0] free_cnt;

  // Lowest-numbered free slot. Searches busy_q only, so a slot freed this
  // cycle is not allocatable until the next one.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = int'(N_TAGS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  assign alloc        = afu_c0_tx_rd_valid & any_free;
  assign rsp_tag      = qlp_c0_rx_hdr[TagW-1:0];
  assign rsp_idx      = rsp_tag[IdxW-1:0];
  assign rsp_in_range = {1'b0, rsp_tag} < (TagW + 1)'(N_TAGS);
  assign rsp_hit      = qlp_c0_rx_rd_valid & rsp_in_range & busy_q[rsp_idx];

  // Alloc and free never target the same slot, so their order is irrelevant.
  always_comb begin
    busy_d = busy_q;
    if (alloc)   busy_d[free_idx] = 1'b1;
    if (rsp_hit) busy_d[rsp_idx]  = 1'b0;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({alloc, rsp_hit})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    err_overflow_d = err_overflow_q | (afu_c0_tx_rd_valid & ~any_free);
    err_unknown_d  = err_unknown_q | (qlp_c0_rx_rd_valid & ~rsp_hit);
    qlp_tx_valid_d = alloc;
    qlp_tx_hdr_d   = {afu_c0_tx_hdr[CCI_TX_HDR_WIDTH-1:TagW], TagW'(free_idx)};
    afu_rx_valid_d = rsp_hit;
    afu_rx_hdr_d   = qlp_c0_rx_hdr;
    if (rsp_hit) begin
      afu_rx_hdr_d = {qlp_c0_rx_hdr[CCI_RX_HDR_WIDTH-1:TagW], tag_mem_q[rsp_idx]};
    end
    afu_rx_data_d  = qlp_c0_rx_data;
    afu_rx_other_d = qlp_c0_rx_other_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q         <= '0;
      outstanding_q  <= '0;
      err_overflow_q <= 1'b0;
      err_unknown_q  <= 1'b0;
      qlp_tx_hdr_q   <= '0;
      qlp_tx_valid_q <= 1'b0;
      afu_rx_hdr_q   <= '0;
      afu_rx_data_q  <= '0;
      afu_rx_valid_q <= 1'b0;
      afu_rx_other_q <= '0;
    end else begin
      busy_q         <= busy_d;
      outstanding_q  <= outstanding_d;
      err_overflow_q <= err_overflow_d;
      err_unknown_q  <= err_unknown_d;
      qlp_tx_hdr_q   <= qlp_tx_hdr_d;
      qlp_tx_valid_q <= qlp_tx_valid_d;
      afu_rx_hdr_q   <= afu_rx_hdr_d;
      afu_rx_data_q  <= afu_rx_data_d;
      afu_rx_valid_q <= afu_rx_valid_d;
      afu_rx_other_q <= afu_rx_other_d;
    end
  end

  // Tag storage is only read for busy slots, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) tag_mem_q[free_idx] <= afu_c0_tx_hdr[TagW-1:0];
  end

  assign free_cnt           = CntW'(N_TAGS) - outstanding_q;
  assign afu_c0_tx_alm_full = reset | qlp_c0_tx_alm_full |
                              (free_cnt <= CntW'(ALM_FULL_THRESH));

  assign qlp_c0_tx_hdr         = qlp_tx_hdr_q;
  assign qlp_c0_tx_rd_valid    = qlp_tx_valid_q;
  assign afu_c0_rx_hdr         = afu_rx_hdr_q;
  assign afu_c0_rx_data        = afu_rx_data_q;
  assign afu_c0_rx_rd_valid    = afu_rx_valid_q;
  assign afu_c0_rx_other_valid = afu_rx_other_q;
  assign outstanding           = outstanding_q;
  assign err_overflow          = err_overflow_q;
  assign err_unknown_tag       = err_unknown_q;

endmodule

// File: tb/tb_qa_shim_c0_read_tag_remap.sv
// Directed bench for qa_shim_c0_read_tag_remap with a slot model and scoreboards.
module tb_qa_shim_c0_read_tag_remap;

  localparam int NT = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [60:0]  afu_c0_tx_hdr;
  logic         afu_c0_tx_rd_valid;
  logic         afu_c0_tx_alm_full;
  logic [17:0]  afu_c0_rx_hdr;
  logic [511:0] afu_c0_rx_data;
  logic         afu_c0_rx_rd_valid;
  logic [3:0]   afu_c0_rx_other_valid;
  logic [60:0]  qlp_c0_tx_hdr;
  logic         qlp_c0_tx_rd_valid;
  logic         qlp_c0_tx_alm_full;
  logic [17:0]  qlp_c0_rx_hdr;
  logic [511:0] qlp_c0_rx_data;
  logic         qlp_c0_rx_rd_valid;
  logic [3:0]   qlp_c0_rx_other_valid;
  logic [6:0]   outstanding;
  logic         err_overflow;
  logic         err_unknown_tag;

  qa_shim_c0_read_tag_remap dut (
    .clk                   (clk),
    .reset                 (reset),
    .afu_c0_tx_hdr         (afu_c0_tx_hdr),
    .afu_c0_tx_rd_valid    (afu_c0_tx_rd_valid),
    .afu_c0_tx_alm_full    (afu_c0_tx_alm_full),
    .afu_c0_rx_hdr         (afu_c0_rx_hdr),
    .afu_c0_rx_data        (afu_c0_rx_data),
    .afu_c0_rx_rd_valid    (afu_c0_rx_rd_valid),
    .afu_c0_rx_other_valid (afu_c0_rx_other_valid),
    .qlp_c0_tx_hdr         (qlp_c0_tx_hdr),
    .qlp_c0_tx_rd_valid    (qlp_c0_tx_rd_valid),
    .qlp_c0_tx_alm_full    (qlp_c0_tx_alm_full),
    .qlp_c0_rx_hdr         (qlp_c0_rx_hdr),
    .qlp_c0_rx_data        (qlp_c0_rx_data),
    .qlp_c0_rx_rd_valid    (qlp_c0_rx_rd_valid),
    .qlp_c0_rx_other_valid (qlp_c0_rx_other_valid),
    .outstanding           (outstanding),
    .err_overflow          (err_overflow),
    .err_unknown_tag       (err_unknown_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]  hdr;
    logic [511:0] data;
  } rx_t;

  logic [60:0] exp_tx_q [$];
  rx_t         exp_rx_q [$];
  logic [3:0]  exp_other;

  // Reference slot model
  bit          m_busy [NT];
  logic [13:0] m_tag  [NT];
  int          m_cnt;
  bit          m_ovf;
  bit          m_unk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic clear_inputs();
    afu_c0_tx_hdr         = '0;
    afu_c0_tx_rd_valid    = 1'b0;
    qlp_c0_tx_alm_full    = 1'b0;
    qlp_c0_rx_hdr         = '0;
    qlp_c0_rx_data        = '0;
    qlp_c0_rx_rd_valid    = 1'b0;
    qlp_c0_rx_other_valid = '0;
    exp_other             = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) m_busy[k] = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unk = 1'b0;
    exp_tx_q.delete();
    exp_rx_q.delete();
  endtask

  // Call before set_rsp in a cycle: allocation sees slots busy before any free.
  task automatic set_req(input logic [13:0] tag);
    logic [46:0] up;
    int idx;
    up  = 47'({$urandom(), $urandom()});
    idx = -1;
    for (int k = NT - 1; k >= 0; k--) if (!m_busy[k]) idx = k;
    afu_c0_tx_hdr      = {up, tag};
    afu_c0_tx_rd_valid = 1'b1;
    if (idx < 0) begin
      m_ovf = 1'b1;
    end else begin
      m_busy[idx] = 1'b1;
      m_tag[idx]  = tag;
      m_cnt++;
      exp_tx_q.push_back({up, 14'(idx)});
    end
  endtask

  task automatic set_rsp(input logic [13:0] tag);
    logic [3:0] up;
    rx_t e;
    up = 4'($urandom());
    qlp_c0_rx_hdr      = {up, tag};
    qlp_c0_rx_data     = rand_data();
    qlp_c0_rx_rd_valid = 1'b1;
    if (tag < 14'(NT) && m_busy[tag[5:0]]) begin
      m_busy[tag[5:0]] = 1'b0;
      m_cnt--;
      e.hdr  = {up, m_tag[tag[5:0]]};
      e.data = qlp_c0_rx_data;
      exp_rx_q.push_back(e);
    end else begin
      m_unk = 1'b1;
    end
  endtask

  // One cycle: sample the registered results of the inputs just driven.
  task automatic tick();
    logic [60:0] et;
    rx_t er;
    @(posedge clk);
    #1;
    if (exp_tx_q.size() != 0) begin
      et = exp_tx_q.pop_front();
      chk("qlp_tx_valid", 512'(qlp_c0_tx_rd_valid), 512'(1));
      chk("qlp_tx_hdr", 512'(qlp_c0_tx_hdr), 512'(et));
    end else begin
      chk("qlp_tx_idle", 512'(qlp_c0_tx_rd_valid), 512'(0));
    end
    if (exp_rx_q.size() != 0) begin
      er = exp_rx_q.pop_front();
      chk("afu_rx_valid", 512'(afu_c0_rx_rd_valid), 512'(1));
      chk("afu_rx_hdr", 512'(afu_c0_rx_hdr), 512'(er.hdr));
      chk("afu_rx_data", afu_c0_rx_data, er.data);
    end else begin
      chk("afu_rx_idle", 512'(afu_c0_rx_rd_valid), 512'(0));
    end
    chk("other_valid", 512'(afu_c0_rx_other_valid), 512'(exp_other));
    chk("outstanding", 512'(outstanding), 512'(m_cnt));
    chk("alm_full", 512'(afu_c0_tx_alm_full), 512'((NT - m_cnt) <= 4));
    chk("err_overflow", 512'(err_overflow), 512'(m_ovf));
    chk("err_unknown_tag", 512'(err_unknown_tag), 512'(m_unk));
    clear_inputs();
  endtask

  initial begin
    logic [17:0]  oh;
    logic [511:0] od;
    clear_inputs();
    model_reset();
    reset = 1'b1;
    #3;
    chk("rst_alm_full", 512'(afu_c0_tx_alm_full), 512'(1));
    chk("rst_outstanding", 512'(outstanding), 512'(0));
    chk("rst_qlp_valid", 512'(qlp_c0_tx_rd_valid), 512'(0));
    chk("rst_afu_valid", 512'(afu_c0_rx_rd_valid), 512'(0));
    chk("rst_qlp_hdr", 512'(qlp_c0_tx_hdr), 512'(0));
    chk("rst_errs", 512'({err_overflow, err_unknown_tag}), 512'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: single read
    set_req(14'h1234);
    tick();
    chk("t1_idx0", 512'(qlp_c0_tx_hdr[13:0]), 512'(0));
    chk("t1_out1", 512'(outstanding), 512'(1));
    set_rsp(14'h0000);
    tick();
    chk("t1_tag", 512'(afu_c0_rx_hdr[13:0]), 512'(14'h1234));
    chk("t1_out0", 512'(outstanding), 512'(0));

    // QLP almost-full passes straight through
    qlp_c0_tx_alm_full = 1'b1;
    #1 chk("qlp_alm_pass", 512'(afu_c0_tx_alm_full), 512'(1));
    qlp_c0_tx_alm_full = 1'b0;
    #1 chk("qlp_alm_clear", 512'(afu_c0_tx_alm_full), 512'(0));

    // Other valids forwarded unchanged
    oh = 18'h3ABCD;
    od = rand_data();
    qlp_c0_rx_hdr         = oh;
    qlp_c0_rx_data        = od;
    qlp_c0_rx_other_valid = 4'b1010;
    exp_other             = 4'b1010;
    tick();
    chk("other_hdr", 512'(afu_c0_rx_hdr), 512'(oh));
    chk("other_data", afu_c0_rx_data, od);

    // 2: pool fill
    for (int i = 0; i < 60; i++) begin
      set_req(14'(100 + i));
      tick();
    end
    chk("t2_alm_at_60", 512'(afu_c0_tx_alm_full), 512'(1));
    for (int i = 60; i < 64; i++) begin
      set_req(14'(100 + i));
      tick();
      chk("t2_hi_idx", 512'(qlp_c0_tx_hdr[13:0]), 512'(i));
    end
    set_req(14'h3FFF);
    tick();
    chk("t2_drop", 512'(qlp_c0_tx_rd_valid), 512'(0));
    chk("t2_ovf", 512'(err_overflow), 512'(1));
    for (int i = 0; i < 64; i++) begin
      set_rsp(14'(i));
      tick();
    end
    chk("t2_drained", 512'(outstanding), 512'(0));

    // 3: out-of-order responses
    set_req(14'h0A); tick();
    set_req(14'h0B); tick();
    set_req(14'h0C); tick();
    set_rsp(14'd2); tick();
    chk("t3_first", 512'(afu_c0_rx_hdr[13:0]), 512'(14'h0C));
    set_rsp(14'd0); tick();
    chk("t3_second", 512'(afu_c0_rx_hdr[13:0]), 512'(14'h0A));
    set_rsp(14'd1); tick();
    chk("t3_third", 512'(afu_c0_rx_hdr[13:0]), 512'(14'h0B));

    // 4: same-cycle allocate and free
    set_req(14'h111); tick();
    set_req(14'h222);
    set_rsp(14'd0);
    tick();
    chk("t4_new_idx1", 512'(qlp_c0_tx_hdr[13:0]), 512'(1));
    chk("t4_net0", 512'(outstanding), 512'(1));
    set_req(14'h333); tick();
    chk("t4_reuse_idx0", 512'(qlp_c0_tx_hdr[13:0]), 512'(0));
    set_rsp(14'd0); tick();
    set_rsp(14'd1); tick();

    // 5: unknown tags
    set_rsp(14'd5); tick();
    chk("t5_unk", 512'(err_unknown_tag), 512'(1));
    tick();
    chk("t5_sticky", 512'(err_unknown_tag), 512'(1));
    set_rsp(14'd70); tick();
    chk("t5_range_drop", 512'(afu_c0_rx_rd_valid), 512'(0));

    // 6: reset mid-flight
    set_req(14'h21); tick();
    set_req(14'h22); tick();
    set_req(14'h23); tick();
    chk("t6_out3", 512'(outstanding), 512'(3));
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_out", 512'(outstanding), 512'(0));
    chk("t6_rst_qlp", 512'(qlp_c0_tx_rd_valid), 512'(0));
    chk("t6_rst_alm", 512'(afu_c0_tx_alm_full), 512'(1));
    chk("t6_rst_unk", 512'(err_unknown_tag), 512'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    set_rsp(14'd1); tick();
    chk("t6_stale_drop", 512'(afu_c0_rx_rd_valid), 512'(0));
    chk("t6_stale_unk", 512'(err_unknown_tag), 512'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
